// File: rtl/tlul_burst_reader_pkg.sv
// Shared types and constants for the TL-UL burst reader and its reorder buffer.
package tlul_burst_reader_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2,
    StDone  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    SlotFree    = 2'd0,
    SlotPending = 2'd1,
    SlotFilled  = 2'd2
  } slot_e;

  localparam logic [2:0] OpGet           = 3'd4;
  localparam logic [2:0] OpAccessAckData = 3'd1;
  localparam logic [1:0] WordSize        = 2'd2;

endpackage

// File: rtl/tlul_pkg.sv
// Minimal TL-UL type package: the host-to-device and device-to-host channel bundles
// shared by the main-memory responder and its initiators.
package tlul_pkg;

  localparam int TL_AW  = 32;
  localparam int TL_DW  = 32;
  localparam int TL_AIW = 8;
  localparam int TL_DIW = 1;
  localparam int TL_DBW = 4;
  localparam int TL_SZW = 2;

  typedef struct packed {
    logic [3:0] instr_type;
    logic [6:0] cmd_intg;
    logic [6:0] data_intg;
  } tl_a_user_t;

  typedef struct packed {
    logic [6:0] rsp_intg;
    logic [6:0] data_intg;
  } tl_d_user_t;

  localparam tl_a_user_t TL_A_USER_DEFAULT = '{
    instr_type: 4'h9,
    cmd_intg:   7'h00,
    data_intg:  7'h00
  };

  typedef struct packed {
    logic              a_valid;
    logic [2:0]        a_opcode;
    logic [2:0]        a_param;
    logic [TL_SZW-1:0] a_size;
    logic [TL_AIW-1:0] a_source;
    logic [TL_AW-1:0]  a_address;
    logic [TL_DBW-1:0] a_mask;
    logic [TL_DW-1:0]  a_data;
    tl_a_user_t        a_user;
    logic              d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic              d_valid;
    logic [2:0]        d_opcode;
    logic [2:0]        d_param;
    logic [TL_SZW-1:0] d_size;
    logic [TL_AIW-1:0] d_source;
    logic [TL_DIW-1:0] d_sink;
    logic [TL_DW-1:0]  d_data;
    tl_d_user_t        d_user;
    logic              d_error;
    logic              a_ready;
  } tl_d2h_t;

endpackage

// File: rtl/tlul_reorder_slots.sv
// Circular reorder buffer: requests claim the tail slot, responses fill any slot by
// index, and the consumer drains strictly from the head so data leaves in issue order.
module tlul_reorder_slots
  import tlul_burst_reader_pkg::*;
#(
  parameter int Depth = 4,
  parameter int IdxW  = $clog2(Depth)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            issue_i,
  input  logic            fill_i,
  input  logic [IdxW-1:0] fill_idx_i,
  input  logic [31:0]     fill_data_i,
  input  logic            pop_i,
  output logic [IdxW-1:0] tail_o,
  output logic            tail_free_o,
  output logic            fill_pending_o,
  output logic            head_valid_o,
  output logic [31:0]     head_data_o
);

  slot_e           state_q [Depth];
  slot_e           state_d [Depth];
  logic [31:0]     data_q  [Depth];
  logic [31:0]     data_d  [Depth];
  logic [IdxW-1:0] head_q, head_d;
  logic [IdxW-1:0] tail_q, tail_d;

  assign tail_o         = tail_q;
  assign tail_free_o    = (state_q[tail_q] == SlotFree);
  assign fill_pending_o = (state_q[fill_idx_i] == SlotPending);
  assign head_valid_o   = (state_q[head_q] == SlotFilled);
  assign head_data_o    = data_q[head_q];

  // Issue, fill and pop only ever target slots in distinct states, so they never collide.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (issue_i) begin
      state_d[tail_q] = SlotPending;
      tail_d          = tail_q + IdxW'(1);
    end else begin
      tail_d = tail_q;
    end
    if (fill_i) begin
      state_d[fill_idx_i] = SlotFilled;
      data_d[fill_idx_i]  = fill_data_i;
    end else begin
      data_d = data_q;
    end
    if (pop_i) begin
      state_d[head_q] = SlotFree;
      head_d          = head_q + IdxW'(1);
    end else begin
      head_d = head_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < Depth; i++) begin
        state_q[i] <= SlotFree;
        data_q[i]  <= 32'h0000_0000;
      end
      head_q <= '0;
      tail_q <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

endmodule

// File: rtl/tlul_burst_reader.sv
// TL-UL read engine: issues Get requests for a contiguous word block, keeps several in
// flight, and streams the responses back out in address order.
module tlul_burst_reader
  import tlul_pkg::*;
  import tlul_burst_reader_pkg::*;
#(
  parameter int MaxOutstanding = 4,
  parameter int CountWidth     = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [31:0]           base_addr_i,
  input  logic [CountWidth-1:0] num_words_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [31:0]           data_o,
  output logic                  data_valid_o,
  input  logic                  data_ready_i,
  output tl_h2d_t               tl_o,
  input  tl_d2h_t               tl_i
);

  localparam int IdxW = $clog2(MaxOutstanding);

  state_e                state_q, state_d;
  logic [31:0]           addr_q, addr_d;
  logic [CountWidth-1:0] num_q, num_d;
  logic [CountWidth-1:0] issued_q, issued_d;
  logic [CountWidth-1:0] delivered_q, delivered_d;
  logic                  err_q, err_d;
  logic                  done_q, done_d;
  logic                  busy_q, busy_d;

  logic            a_valid, a_hs, pop;
  logic            src_ok, fill_pending, d_good, d_bad;
  logic [IdxW-1:0] tail;
  logic            tail_free;
  logic            unused_tl_fields;

  assign unused_tl_fields = ^{tl_i.d_param, tl_i.d_size, tl_i.d_sink, tl_i.d_user,
                              base_addr_i[1:0]};

  assign a_valid = (state_q == StRun) && tail_free;
  assign a_hs    = a_valid && tl_i.a_ready;
  assign pop     = data_valid_o && data_ready_i;

  // Sources beyond the slot range can never match an outstanding request.
  assign src_ok = ({{(32-TL_AIW){1'b0}}, tl_i.d_source} < 32'(MaxOutstanding));
  assign d_good = tl_i.d_valid && src_ok && fill_pending && (tl_i.d_opcode == OpAccessAckData);
  assign d_bad  = tl_i.d_valid && (!d_good || tl_i.d_error);

  tlul_reorder_slots #(
    .Depth (MaxOutstanding),
    .IdxW  (IdxW)
  ) u_slots (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .issue_i        (a_hs),
    .fill_i         (d_good),
    .fill_idx_i     (tl_i.d_source[IdxW-1:0]),
    .fill_data_i    (tl_i.d_data),
    .pop_i          (pop),
    .tail_o         (tail),
    .tail_free_o    (tail_free),
    .fill_pending_o (fill_pending),
    .head_valid_o   (data_valid_o),
    .head_data_o    (data_o)
  );

  // Command FSM and counters; done is raised directly on the last pop so it lands one cycle later.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    num_d       = num_q;
    issued_d    = issued_q;
    delivered_d = delivered_q;
    err_d       = err_q;
    done_d      = 1'b0;
    if (pop) begin
      delivered_d = delivered_q + CountWidth'(1);
    end else begin
      delivered_d = delivered_q;
    end
    case (state_q)
      StIdle: begin
        if (start_i) begin
          err_d       = 1'b0;
          addr_d      = {base_addr_i[31:2], 2'b00};
          num_d       = num_words_i;
          issued_d    = '0;
          delivered_d = '0;
          if (num_words_i != '0) begin
            state_d = StRun;
          end else begin
            state_d = StDone;
          end
        end else begin
          state_d = StIdle;
        end
      end
      StRun: begin
        if (a_hs) begin
          addr_d   = addr_q + 32'd4;
          issued_d = issued_q + CountWidth'(1);
          if ((issued_q + CountWidth'(1)) == num_q) begin
            state_d = StDrain;
          end else begin
            state_d = StRun;
          end
        end else begin
          state_d = StRun;
        end
      end
      StDrain: begin
        if (pop && ((delivered_q + CountWidth'(1)) == num_q)) begin
          state_d = StDone;
          done_d  = 1'b1;
        end else begin
          state_d = StDrain;
        end
      end
      StDone: begin
        state_d = StIdle;
        done_d  = !done_q;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    if (d_bad) begin
      err_d = 1'b1;
    end else begin
      err_d = err_d;
    end
  end

  assign busy_d = (state_d != StIdle) || done_d;

  // A-channel request fields are pure functions of registered state, so they hold while stalled.
  always_comb begin
    tl_o           = '0;
    tl_o.a_valid   = a_valid;
    tl_o.a_opcode  = OpGet;
    tl_o.a_param   = 3'd0;
    tl_o.a_size    = WordSize;
    tl_o.a_source  = TL_AIW'(tail);
    tl_o.a_address = addr_q;
    tl_o.a_mask    = 4'hF;
    tl_o.a_data    = 32'h0000_0000;
    tl_o.a_user    = TL_A_USER_DEFAULT;
    tl_o.d_ready   = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      addr_q      <= 32'h0000_0000;
      num_q       <= '0;
      issued_q    <= '0;
      delivered_q <= '0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      num_q       <= num_d;
      issued_q    <= issued_d;
      delivered_q <= delivered_d;
      err_q       <= err_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign err_o  = err_q;

endmodule

// File: tb/tb_tlul_burst_reader.sv
// Directed bench for tlul_burst_reader: a behavioural TL-UL responder returning ~addr as data,
// a stream logger, and a linear sequence of scenarios with hand-computed expectations.
module tb_tlul_burst_reader;
  import tlul_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] base;
  logic [15:0] num;
  logic        busy, done, err;
  logic [31:0] data;
  logic        dvalid, dready;
  tl_h2d_t     tl_o_s;
  tl_d2h_t     tl_i_s;

  always #5 clk = ~clk;

  tlul_burst_reader dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .start_i      (start),
    .base_addr_i  (base),
    .num_words_i  (num),
    .busy_o       (busy),
    .done_o       (done),
    .err_o        (err),
    .data_o       (data),
    .data_valid_o (dvalid),
    .data_ready_i (dready),
    .tl_o         (tl_o_s),
    .tl_i         (tl_i_s)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  src;
  } req_t;

  req_t        pend[$];
  req_t        alog[$];
  logic [31:0] got[$];
  logic [7:0]  ord[$];
  int          done_cnt  = 0;
  int          resp_mode = 0;
  int          unsol_req = 0;
  int          unsol_sent = 0;
  logic        err_en    = 1'b0;
  logic [31:0] err_addr  = 32'h0;
  int          total     = 0;
  int          bad       = 0;

  // Responder/monitor: at the falling edge, log handshakes that the next rising edge completes
  // and pick the next D beat from requests accepted on earlier edges.
  always @(negedge clk) begin
    req_t        r;
    req_t        p;
    logic        hit;
    logic        dv;
    logic [7:0]  dsrc;
    logic [31:0] daddr;
    logic [31:0] ddata;
    hit = 1'b0; dv = 1'b0; dsrc = 8'h0; daddr = 32'h0; ddata = 32'h0; r = '0; p = '0;
    if (rst_n && tl_o_s.a_valid && tl_i_s.a_ready) begin
      hit = 1'b1; r.addr = tl_o_s.a_address; r.src = tl_o_s.a_source;
    end
    if (rst_n && dvalid && dready) got.push_back(data);
    if (rst_n && done) done_cnt++;
    if (unsol_sent < unsol_req) begin
      dv = 1'b1; dsrc = 8'd3; ddata = 32'hDEAD_BEEF; daddr = 32'hFFFF_FFFF; unsol_sent++;
    end else if (resp_mode == 0 && pend.size() > 0) begin
      p = pend.pop_front(); dv = 1'b1; dsrc = p.src; daddr = p.addr; ddata = ~p.addr;
    end else if (resp_mode == 1 && ord.size() > 0) begin
      for (int i = 0; i < pend.size(); i++) begin
        if (pend[i].src == ord[0]) begin
          p = pend[i]; pend.delete(i); void'(ord.pop_front());
          dv = 1'b1; dsrc = p.src; daddr = p.addr; ddata = ~p.addr;
          break;
        end
      end
    end
    if (hit) begin pend.push_back(r); alog.push_back(r); end
    tl_i_s          = '0;
    tl_i_s.a_ready  = 1'b1;
    tl_i_s.d_valid  = dv;
    tl_i_s.d_opcode = 3'd1;
    tl_i_s.d_size   = 2'd2;
    tl_i_s.d_source = dsrc;
    tl_i_s.d_data   = ddata;
    tl_i_s.d_error  = err_en && dv && (daddr == err_addr);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_start(input logic [31:0] b, input logic [15:0] n);
    base = b; num = n; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int d0, input string tag);
    int n = 0;
    while (done_cnt == d0 && n < 300) begin tick(); n++; end
    check(tag, 32'(done_cnt - d0), 32'd1);
  endtask

  task automatic check_stream(input string tag, input int g0, input logic [31:0] b, input int n);
    check({tag, " count"}, 32'(got.size() - g0), 32'(n));
    for (int i = 0; i < n && (g0 + i) < got.size(); i++)
      check({tag, " word"}, got[g0 + i], ~(b + 32'(4 * i)));
  endtask

  task automatic check_addrs(input string tag, input int a0, input logic [31:0] b, input int n);
    check({tag, " reqs"}, 32'(alog.size() - a0), 32'(n));
    for (int i = 0; i < n && (a0 + i) < alog.size(); i++)
      check({tag, " addr"}, alog[a0 + i].addr, b + 32'(4 * i));
  endtask

  initial begin
    int a0;
    int g0;
    int d0;
    rst_n = 1'b0; start = 1'b0; base = 32'h0; num = 16'h0; dready = 1'b1;
    tick(); tick();
    check("rst busy", {31'b0, busy}, 32'd0);
    check("rst done", {31'b0, done}, 32'd0);
    check("rst err", {31'b0, err}, 32'd0);
    check("rst dvalid", {31'b0, dvalid}, 32'd0);
    check("rst a_valid", {31'b0, tl_o_s.a_valid}, 32'd0);
    check("rst data", data, 32'h0);
    check("rst d_ready", {31'b0, tl_o_s.d_ready}, 32'd1);
    rst_n = 1'b1;
    tick();

    // In-order responder, 8 words from 0x1000.
    a0 = alog.size(); g0 = got.size(); d0 = done_cnt;
    run_start(32'h0000_1000, 16'd8);
    check("t1 busy", {31'b0, busy}, 32'd1);
    check("t1 a_valid", {31'b0, tl_o_s.a_valid}, 32'd1);
    check("t1 opcode", {29'b0, tl_o_s.a_opcode}, 32'd4);
    check("t1 mask", {28'b0, tl_o_s.a_mask}, 32'hF);
    wait_done(d0, "t1 done");
    check("t1 busy after", {31'b0, busy}, 32'd0);
    check("t1 err", {31'b0, err}, 32'd0);
    check_addrs("t1", a0, 32'h0000_1000, 8);
    for (int i = 0; i < 8 && (a0 + i) < alog.size(); i++)
      check("t1 src", {24'b0, alog[a0 + i].src}, 32'(i % 4));
    check_stream("t1", g0, 32'h0000_1000, 8);
    repeat (5) tick();
    check("t1 single done", 32'(done_cnt - d0), 32'd1);

    // Out-of-order returns 3,1,0,2.
    ord.push_back(8'd3); ord.push_back(8'd1); ord.push_back(8'd0); ord.push_back(8'd2);
    resp_mode = 1;
    a0 = alog.size(); g0 = got.size(); d0 = done_cnt;
    run_start(32'h0000_2000, 16'd4);
    wait_done(d0, "t2 done");
    check_addrs("t2", a0, 32'h0000_2000, 4);
    check_stream("t2", g0, 32'h0000_2000, 4);
    resp_mode = 0;

    // Consumer stalled: only four requests may be in flight.
    dready = 1'b0;
    a0 = alog.size(); g0 = got.size(); d0 = done_cnt;
    run_start(32'h0000_3000, 16'd6);
    repeat (20) tick();
    check("t3 stalled reqs", 32'(alog.size() - a0), 32'd4);
    check("t3 stalled a_valid", {31'b0, tl_o_s.a_valid}, 32'd0);
    check("t3 head valid", {31'b0, dvalid}, 32'd1);
    check("t3 head data", data, ~32'h0000_3000);
    dready = 1'b1;
    wait_done(d0, "t3 done");
    check_addrs("t3", a0, 32'h0000_3000, 6);
    check_stream("t3", g0, 32'h0000_3000, 6);

    // Address wrap at the top of the 32-bit space.
    a0 = alog.size(); g0 = got.size(); d0 = done_cnt;
    run_start(32'hFFFF_FFF8, 16'd4);
    wait_done(d0, "t4 done");
    check_addrs("t4", a0, 32'hFFFF_FFF8, 4);
    check_stream("t4", g0, 32'hFFFF_FFF8, 4);

    // d_error on word 2: still delivered, err set.
    err_en = 1'b1; err_addr = 32'h0000_4008;
    a0 = alog.size(); g0 = got.size(); d0 = done_cnt;
    run_start(32'h0000_4000, 16'd4);
    wait_done(d0, "t5 done");
    err_en = 1'b0;
    check("t5 err", {31'b0, err}, 32'd1);
    check_stream("t5", g0, 32'h0000_4000, 4);

    // Zero-length command: clears err, no traffic, done two cycles after start.
    a0 = alog.size(); d0 = done_cnt;
    run_start(32'h0000_7000, 16'd0);
    check("t6 busy c1", {31'b0, busy}, 32'd1);
    check("t6 done c1", {31'b0, done}, 32'd0);
    check("t6 err cleared", {31'b0, err}, 32'd0);
    tick();
    check("t6 done c2", {31'b0, done}, 32'd1);
    check("t6 busy c2", {31'b0, busy}, 32'd1);
    tick();
    check("t6 done c3", {31'b0, done}, 32'd0);
    check("t6 busy c3", {31'b0, busy}, 32'd0);
    check("t6 no reqs", 32'(alog.size() - a0), 32'd0);

    // Unsolicited beat while idle.
    unsol_req++;
    repeat (3) tick();
    check("t7 unsolicited err", {31'b0, err}, 32'd1);
    run_start(32'h0000_7000, 16'd0);
    check("t7 err cleared", {31'b0, err}, 32'd0);
    repeat (3) tick();

    // Reset mid-transfer with responses still outstanding.
    run_start(32'h0000_5000, 16'd16);
    repeat (3) tick();
    resp_mode = 2;
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    check("t8 rst busy", {31'b0, busy}, 32'd0);
    check("t8 rst dvalid", {31'b0, dvalid}, 32'd0);
    check("t8 rst a_valid", {31'b0, tl_o_s.a_valid}, 32'd0);
    check("t8 rst data", data, 32'h0);
    check("t8 rst err", {31'b0, err}, 32'd0);
    tick();
    rst_n = 1'b1;
    resp_mode = 0;
    repeat (8) tick();
    check("t8 stale err", {31'b0, err}, 32'd1);
    a0 = alog.size(); g0 = got.size(); d0 = done_cnt;
    run_start(32'h0000_6000, 16'd3);
    wait_done(d0, "t8 done");
    check("t8 err after", {31'b0, err}, 32'd0);
    check_addrs("t8", a0, 32'h0000_6000, 3);
    check_stream("t8", g0, 32'h0000_6000, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
